frog_game_ctrl: RTL and testbench

FROG_GAME_CTRL -- requirements
Module: frog_game_ctrl

---
 rtl/frog_game_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_frog_game_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/frog_game_ctrl.sv
// frog_game_ctrl
//   Game sequencing controller for the frog crossing game. Turns button edges
//   into rate-limited move commands and steps through the play, dying, win
//   and game-over phases. Phase and cooldown timers count frame ticks.
//
//   State table
//     state | meaning
//     IDLE  | waiting for any press to start a game
//     PLAY  | frog moving; die/win monitored, moves rate-limited by cooldown
//     DYING | death animation, DEATH_TICKS ticks, then respawn or game over
//     WINP  | crossing celebration, WIN_TICKS ticks, then respawn
//     OVER  | no lives left; any press returns to IDLE with a fresh game
//
// Ports
//   clk                              : system clock, rising edge
//   rst                              : asynchronous active-high reset
//   btnUp/btnDown/btnLeft/btnRight   : button levels, synchronous to clk
//   tick                             : one-cycle frame strobe
//   die, win                         : collision / frog-at-goal levels
//   mv_up/mv_down/mv_left/mv_right   : registered one-cycle move commands
//   respawn                          : registered one-cycle return-to-start
//   lives [1:0]                      : lives remaining
//   level [3:0]                      : completed crossings, saturating at 15
//   state [2:0]                      : IDLE=0 PLAY=1 DYING=2 WINP=3 OVER=4
//   game_over                        : high while in OVER
module frog_game_ctrl #(
  parameter int COOLDOWN    = 4,
  parameter int DEATH_TICKS = 30,
  parameter int WIN_TICKS   = 30,
  parameter int START_LIVES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnUp,
  input  logic       btnDown,
  input  logic       btnLeft,
  input  logic       btnRight,
  input  logic       tick,
  input  logic       die,
  input  logic       win,
  output logic       mv_up,
  output logic       mv_down,
  output logic       mv_left,
  output logic       mv_right,
  output logic       respawn,
  output logic [1:0] lives,
  output logic [3:0] level,
  output logic [2:0] state,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_DYING = 3'd2,
    S_WINP  = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam int CW   = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam int TMAX = (DEATH_TICKS > WIN_TICKS) ? DEATH_TICKS : WIN_TICKS;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);

  localparam logic [CW-1:0] COOL_LOAD  = CW'(COOLDOWN);
  localparam logic [TW-1:0] DEATH_LAST = TW'(DEATH_TICKS - 1);
  localparam logic [TW-1:0] WIN_LAST   = TW'(WIN_TICKS - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(START_LIVES);

  // Button vectors are ordered {up, down, left, right}
  state_t          r_state;
  logic [3:0]      r_btn_q;
  logic [CW-1:0]   r_cool;
  logic [TW-1:0]   r_tcnt;
  logic [1:0]      r_lives;
  logic [3:0]      r_level;
  logic [3:0]      r_mv;
  logic            r_respawn;
  logic            r_game_over;

  state_t          w_state_nxt;
  logic [CW-1:0]   w_cool_nxt;
  logic [TW-1:0]   w_tcnt_nxt;
  logic [1:0]      w_lives_nxt;
  logic [3:0]      w_level_nxt;
  logic [3:0]      w_mv_nxt;
  logic            w_respawn_nxt;
  logic [3:0]      w_btn;
  logic [3:0]      w_press;
  logic            w_any_press;

  assign w_btn       = {btnUp, btnDown, btnLeft, btnRight};
  assign w_press     = w_btn & ~r_btn_q;
  assign w_any_press = |w_press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_btn_q     <= '0;
      r_cool      <= '0;
      r_tcnt      <= '0;
      r_lives     <= LIVES_INIT;
      r_level     <= '0;
      r_mv        <= '0;
      r_respawn   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_btn_q     <= w_btn;
      r_cool      <= w_cool_nxt;
      r_tcnt      <= w_tcnt_nxt;
      r_lives     <= w_lives_nxt;
      r_level     <= w_level_nxt;
      r_mv        <= w_mv_nxt;
      r_respawn   <= w_respawn_nxt;
      r_game_over <= (w_state_nxt == S_OVER);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cool_nxt    = r_cool;
    w_lives_nxt   = r_lives;
    w_level_nxt   = r_level;
    w_mv_nxt      = 4'b0000;
    w_respawn_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_any_press) begin
          w_state_nxt   = S_PLAY;
          w_respawn_nxt = 1'b1;
          w_cool_nxt    = '0;
        end
      end

      S_PLAY: begin
        if (tick && (r_cool != '0)) w_cool_nxt = r_cool - CW'(1);
        if (die) begin
          w_state_nxt = S_DYING;
        end else if (win) begin
          w_state_nxt = S_WINP;
          if (r_level != 4'hF) w_level_nxt = r_level + 4'd1;
        end else if ((r_cool == '0) && w_any_press) begin
          // Simultaneous presses resolve to one move: Down > Up > Right > Left
          w_cool_nxt = COOL_LOAD;
          if (w_press[2])      w_mv_nxt = 4'b0100;
          else if (w_press[3]) w_mv_nxt = 4'b1000;
          else if (w_press[0]) w_mv_nxt = 4'b0001;
          else                 w_mv_nxt = 4'b0010;
        end
      end

      S_DYING: begin
        if (tick && (r_tcnt == DEATH_LAST)) begin
          if (r_lives == 2'd1) begin
            w_lives_nxt = 2'd0;
            w_state_nxt = S_OVER;
          end else begin
            w_lives_nxt   = r_lives - 2'd1;
            w_respawn_nxt = 1'b1;
            w_state_nxt   = S_PLAY;
            w_cool_nxt    = '0;
          end
        end
      end

      S_WINP: begin
        if (tick && (r_tcnt == WIN_LAST)) begin
          w_respawn_nxt = 1'b1;
          w_state_nxt   = S_PLAY;
          w_cool_nxt    = '0;
        end
      end

      S_OVER: begin
        if (w_any_press) begin
          w_state_nxt = S_IDLE;
          w_lives_nxt = LIVES_INIT;
          w_level_nxt = 4'd0;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    // Phase timer restarts on any state change, so a tick in the
    // transition cycle never counts toward the new phase
    w_tcnt_nxt = r_tcnt;
    if (w_state_nxt != r_state) begin
      w_tcnt_nxt = '0;
    end else if (tick && ((r_state == S_DYING) || (r_state == S_WINP))) begin
      w_tcnt_nxt = r_tcnt + TW'(1);
    end
  end

  assign mv_up     = r_mv[3];
  assign mv_down   = r_mv[2];
  assign mv_left   = r_mv[1];
  assign mv_right  = r_mv[0];
  assign respawn   = r_respawn;
  assign lives     = r_lives;
  assign level     = r_level;
  assign state     = r_state;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_frog_game_ctrl.sv
// tb_frog_game_ctrl
//   Directed scenarios followed by a randomized run of frog_game_ctrl, with
//   every cycle compared against a behavioural game model that tracks the
//   phases as "ticks remaining" and the cooldown as a plain integer.
module tb_frog_game_ctrl;

  localparam int P_COOL  = 4;
  localparam int P_DEATH = 30;
  localparam int P_WIN   = 30;
  localparam int P_LIVES = 3;

  localparam logic [3:0] UP = 4'b1000;
  localparam logic [3:0] DN = 4'b0100;
  localparam logic [3:0] LT = 4'b0010;
  localparam logic [3:0] RT = 4'b0001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btnUp = 1'b0, btnDown = 1'b0, btnLeft = 1'b0, btnRight = 1'b0;
  logic       tick = 1'b0, die = 1'b0, win = 1'b0;
  logic       mv_up, mv_down, mv_left, mv_right, respawn, game_over;
  logic [1:0] lives;
  logic [3:0] level;
  logic [2:0] state;

  always #5 clk = ~clk;

  frog_game_ctrl #(
    .COOLDOWN(P_COOL), .DEATH_TICKS(P_DEATH), .WIN_TICKS(P_WIN), .START_LIVES(P_LIVES)
  ) dut (
    .clk(clk), .rst(rst),
    .btnUp(btnUp), .btnDown(btnDown), .btnLeft(btnLeft), .btnRight(btnRight),
    .tick(tick), .die(die), .win(win),
    .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left), .mv_right(mv_right),
    .respawn(respawn), .lives(lives), .level(level), .state(state),
    .game_over(game_over)
  );

  logic [14:0] w_obs;
  assign w_obs = {mv_up, mv_down, mv_left, mv_right, respawn, lives, level, state, game_over};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 idle, 1 play, 2 dying, 3 win, 4 over
  int         m_mode, m_lives, m_level, m_cool, m_left;
  logic [3:0] m_bq;
  logic [3:0] e_mv;
  logic       e_resp;

  function automatic logic [14:0] exp_vec();
    return {e_mv, e_resp, 2'(m_lives), 4'(m_level), 3'(m_mode), (m_mode == 4)};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_lives = P_LIVES; m_level = 0; m_cool = 0; m_left = 0;
    m_bq = 4'b0; e_mv = 4'b0; e_resp = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] b, input logic t, input logic d, input logic w);
    logic [3:0] p;
    bit can_move;
    p = b & ~m_bq;
    m_bq = b;
    e_mv = 4'b0;
    e_resp = 1'b0;
    case (m_mode)
      0: if (p != 0) begin m_mode = 1; e_resp = 1'b1; m_cool = 0; end
      1: begin
        can_move = (m_cool == 0);
        if (t && m_cool > 0) m_cool = m_cool - 1;
        if (d) begin
          m_mode = 2; m_left = P_DEATH;
        end else if (w) begin
          m_mode = 3; m_left = P_WIN;
          if (m_level < 15) m_level = m_level + 1;
        end else if (can_move && p != 0) begin
          m_cool = P_COOL;
          if (p[2])      e_mv = DN;
          else if (p[3]) e_mv = UP;
          else if (p[0]) e_mv = RT;
          else           e_mv = LT;
        end
      end
      2: if (t) begin
        if (m_left == 1) begin
          if (m_lives == 1) begin m_lives = 0; m_mode = 4; end
          else begin m_lives = m_lives - 1; e_resp = 1'b1; m_mode = 1; m_cool = 0; end
        end else m_left = m_left - 1;
      end
      3: if (t) begin
        if (m_left == 1) begin e_resp = 1'b1; m_mode = 1; m_cool = 0; end
        else m_left = m_left - 1;
      end
      default: if (p != 0) begin m_mode = 0; m_lives = P_LIVES; m_level = 0; end
    endcase
  endtask

  task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input logic [3:0] b, input logic t, input logic d, input logic w, input string tag);
    @(negedge clk);
    {btnUp, btnDown, btnLeft, btnRight} = b;
    tick = t; die = d; win = w;
    model_step(b, t, d, w);
    @(posedge clk);
    #1;
    check(tag, w_obs, exp_vec());
  endtask

  // Asserts rst away from any clock edge, checks the asynchronous effect,
  // then releases at a falling edge with hb held on the buttons.
  task automatic reset_pulse(input string tag, input logic [3:0] hb);
    rst = 1'b1;
    {btnUp, btnDown, btnLeft, btnRight} = 4'b0;
    tick = 1'b0; die = 1'b0; win = 1'b0;
    #1;
    model_reset();
    check({tag, "_async"}, w_obs, exp_vec());
    @(posedge clk);
    #1;
    check({tag, "_held"}, w_obs, exp_vec());
    @(negedge clk);
    {btnUp, btnDown, btnLeft, btnRight} = hb;
    rst = 1'b0;
    model_step(hb, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check({tag, "_release"}, w_obs, exp_vec());
  endtask

  initial begin
    logic [3:0] rb;
    model_reset();
    #1;
    reset_pulse("reset", 4'b0);

    // Start game, then single move from a held button
    cyc(RT, 0, 0, 0, "start");
    chk("start_respawn", 16'(respawn), 16'd1);
    chk("start_state", 16'(state), 16'd1);
    cyc(0, 0, 0, 0, "gap");
    cyc(RT, 0, 0, 0, "mv_right");
    chk("mv_right_pulse", 16'(mv_right), 16'd1);
    repeat (3) cyc(RT, 0, 0, 0, "held_right");
    cyc(0, 0, 0, 0, "release");

    // Priority and cooldown discard
    repeat (4) cyc(0, 1, 0, 0, "cool_drain");
    cyc(DN | LT, 0, 0, 0, "down_left");
    chk("down_wins", 16'({mv_down, mv_left}), 16'd2);
    cyc(0, 0, 0, 0, "gap");
    repeat (2) cyc(0, 1, 0, 0, "cool_tick");
    cyc(UP, 0, 0, 0, "up_discard");
    chk("up_discard_none", 16'(mv_up), 16'd0);
    cyc(0, 0, 0, 0, "gap");
    repeat (2) cyc(0, 1, 0, 0, "cool_tick");
    cyc(UP, 0, 0, 0, "up_move");
    chk("up_move_pulse", 16'(mv_up), 16'd1);
    cyc(0, 0, 0, 0, "gap");

    // Die beats a simultaneous press
    repeat (4) cyc(0, 1, 0, 0, "cool_drain");
    cyc(UP, 0, 1, 0, "die_press");
    chk("die_state", 16'(state), 16'd2);
    repeat (P_DEATH) cyc(0, 1, 0, 0, "dying");
    chk("death1_lives", 16'(lives), 16'd2);
    chk("death1_respawn", 16'(respawn), 16'd1);

    // Level saturation over 16 crossings
    repeat (16) begin
      cyc(0, 0, 0, 1, "win");
      repeat (P_WIN) cyc(0, 1, 0, 0, "winp");
    end
    chk("level_sat", 16'(level), 16'd15);

    // Last two deaths end the game
    repeat (2) begin
      cyc(0, 0, 1, 0, "die");
      repeat (P_DEATH) cyc(0, 1, 0, 0, "dying");
    end
    chk("over_state", 16'(state), 16'd4);
    chk("over_flag", 16'(game_over), 16'd1);
    chk("over_no_respawn", 16'(respawn), 16'd0);
    cyc(RT, 0, 0, 0, "over_press");
    chk("new_game_lives", 16'(lives), 16'd3);
    chk("new_game_level", 16'(level), 16'd0);

    // Reset in the middle of DYING abandons the phase
    cyc(UP, 0, 0, 0, "start2");
    cyc(0, 0, 0, 0, "gap");
    cyc(0, 0, 1, 0, "die2");
    repeat (10) cyc(0, 1, 0, 0, "dying2");
    reset_pulse("mid_dying", 4'b0);
    chk("mid_dying_lives", 16'(lives), 16'd3);
    repeat (40) cyc(0, 1, 0, 0, "after_rst");

    // Button held across reset release is a press
    reset_pulse("held_btn", LT);
    chk("held_btn_respawn", 16'(respawn), 16'd1);

    // Randomized play
    rb = LT;
    for (int i = 0; i < 2500; i++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(3) == 0) rb[k] = ~rb[k];
      if ($urandom_range(599) == 0) begin
        reset_pulse("rand_rst", rb);
      end else begin
        cyc(rb, 1'($urandom_range(1)), ($urandom_range(29) == 0),
            ($urandom_range(39) == 0), "random");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
